// File: rtl/mv_stream_loader.sv
// Packs a 16-bit element stream into 32-bit BRAM words, then
// kicks the matrix-vector compute block and waits for it.
//
// Ports:
//   aclk, aresetn         clock, synchronous active-low reset
//   arm                   start a transaction (only seen when idle)
//   s_data/s_valid/s_last element stream in; s_ready back
//   BRAM_ADDR/WRDATA/WE   write port, all-zero when not writing
//   pe_start/pe_done      handshake with the compute block
//   busy/done_o/err       status; err is sticky framing error
module mv_stream_loader #(
    parameter int          VECTOR_SIZE = 64,
    parameter logic [31:0] ADDR_BASE   = 32'h0
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        arm,
    input  logic [15:0] s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [31:0] BRAM_ADDR,
    output logic [31:0] BRAM_WRDATA,
    output logic [3:0]  BRAM_WE,
    output logic        pe_start,
    input  logic        pe_done,
    output logic        busy,
    output logic        done_o,
    output logic        err
);

    localparam int WORDS =
        (VECTOR_SIZE * VECTOR_SIZE + VECTOR_SIZE) / 2;
    localparam int IW = $clog2(WORDS + 1);
    localparam logic [IW-1:0] LAST_WORD = IW'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_START,
        S_WAIT
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [IW-1:0] word_idx;
    logic          half;
    logic [15:0]   hi;
    logic          err_q;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   data_q;

    logic arm_ok;
    logic beat;
    logic wr_beat;
    logic last_beat;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        arm_ok    = 1'b0;
        beat      = 1'b0;
        wr_beat   = 1'b0;
        last_beat = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (arm) begin
                    arm_ok  = 1'b1;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                beat      = s_valid;
                wr_beat   = s_valid && half;
                last_beat = wr_beat && (word_idx == LAST_WORD);
                if (last_beat) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (pe_done) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are masked by aresetn so that they read zero
        // while reset is held, which also squashes a write that
        // was registered just before reset arrived.
        s_ready     = aresetn && (state_q == S_FILL);
        pe_start    = aresetn && (state_q == S_START);
        busy        = aresetn && (state_q != S_IDLE);
        done_o      = aresetn && (state_q == S_WAIT) && pe_done;
        err         = aresetn && err_q;
        BRAM_WE     = {4{aresetn && we_q}};
        BRAM_ADDR   = (aresetn && we_q) ? addr_q : 32'h0;
        BRAM_WRDATA = (aresetn && we_q) ? data_q : 32'h0;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            word_idx <= '0;
            half     <= 1'b0;
            hi       <= 16'h0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            data_q   <= 32'h0;
        end else begin
            we_q   <= wr_beat;
            addr_q <= wr_beat
                ? ADDR_BASE + (32'(word_idx) << 2) : 32'h0;
            data_q <= wr_beat ? {hi, s_data} : 32'h0;
            if (arm_ok) begin
                word_idx <= '0;
                half     <= 1'b0;
                err_q    <= 1'b0;
            end
            if (beat) begin
                if (!half) begin
                    hi   <= s_data;
                    half <= 1'b1;
                end else begin
                    half     <= 1'b0;
                    word_idx <= word_idx + 1'b1;
                end
                // s_last must coincide exactly with the final
                // element; either mismatch is a framing error.
                if (s_last != last_beat) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mv_stream_loader.sv
// Bench for mv_stream_loader: table of stream scenarios, a
// write scoreboard, and hand-written reset/abort sequences.
module tb_mv_stream_loader;

    localparam int          N     = 64;
    localparam int          TOTAL = N * N + N;
    localparam int          WORDS = TOTAL / 2;
    localparam logic [31:0] BASE  = 32'h0000_4000;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        arm;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [31:0] BRAM_ADDR;
    logic [31:0] BRAM_WRDATA;
    logic [3:0]  BRAM_WE;
    logic        pe_start;
    logic        pe_done;
    logic        busy;
    logic        done_o;
    logic        err;

    mv_stream_loader #(
        .VECTOR_SIZE(N),
        .ADDR_BASE  (BASE)
    ) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .arm        (arm),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .BRAM_ADDR  (BRAM_ADDR),
        .BRAM_WRDATA(BRAM_WRDATA),
        .BRAM_WE    (BRAM_WE),
        .pe_start   (pe_start),
        .pe_done    (pe_done),
        .busy       (busy),
        .done_o     (done_o),
        .err        (err)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int gap;
        int slast;
        int arm_at;
        int dly;
        bit err_mid;
        bit err_end;
    } vec_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    vec_t vecs[5];
    wr_t  sb_q[$];
    int   n_chk    = 0;
    int   n_fail   = 0;
    int   wr_cnt   = 0;
    int   pe_cnt   = 0;
    int   done_cnt = 0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    always @(negedge aclk) begin : mon
        wr_t e;
        if (pe_start === 1'b1) pe_cnt++;
        if (done_o === 1'b1) done_cnt++;
        if (BRAM_WE !== 4'h0) begin
            wr_cnt++;
            chk("bram_we", 32'(BRAM_WE), 32'hF);
            chk("write_expected", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("bram_addr", BRAM_ADDR, e.addr);
                chk("bram_data", BRAM_WRDATA, e.data);
            end
        end else begin
            chk("idle_addr", BRAM_ADDR, 32'h0);
            chk("idle_data", BRAM_WRDATA, 32'h0);
        end
    end

    task automatic send(input int i, input bit last,
                        output bit ok);
        int t;
        wr_t e;
        t       = 0;
        s_valid = 1'b1;
        s_data  = 16'(i);
        s_last  = last;
        while (s_ready !== 1'b1 && t < 10) begin
            @(posedge aclk);
            #1;
            t++;
        end
        if (s_ready !== 1'b1) begin
            n_chk++;
            n_fail++;
            $display("FAIL s_ready_timeout: elem %0d", i);
            ok = 1'b0;
            return;
        end
        @(posedge aclk);
        if (i % 2 == 1) begin
            e.addr = BASE + 32'(4 * (i / 2));
            e.data = {16'(i - 1), 16'(i)};
            sb_q.push_back(e);
        end
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        ok      = 1'b1;
    endtask

    task automatic arm_it();
        arm = 1'b1;
        @(posedge aclk);
        #1;
        arm = 1'b0;
    endtask

    task automatic run_txn(input vec_t v);
        bit ok;
        int pe0;
        int w0;
        int d0;
        pe0 = pe_cnt;
        w0  = wr_cnt;
        d0  = done_cnt;
        arm_it();
        chk("err_cleared_on_arm", 32'(err), 0);
        chk("s_ready_fill", 32'(s_ready), 1);
        chk("busy_fill", 32'(busy), 1);
        for (int i = 0; i < TOTAL; i++) begin
            while (int'($urandom_range(0, 99)) < v.gap) begin
                s_valid = 1'b0;
                s_data  = 16'($urandom);
                s_last  = 1'($urandom);
                @(posedge aclk);
                #1;
            end
            if (i == 200) chk("err_mid", 32'(err), 32'(v.err_mid));
            arm = (i == v.arm_at);
            send(i, i == v.slast, ok);
            arm = 1'b0;
            if (!ok) return;
        end
        chk("s_ready_after_last", 32'(s_ready), 0);
        chk("pe_start_on", 32'(pe_start), 1);
        @(posedge aclk);
        #1;
        chk("pe_start_off", 32'(pe_start), 0);
        chk("busy_start", 32'(busy), 1);
        for (int c = 0; c < v.dly; c++) begin
            arm = (c == 10);
            chk("busy_wait", 32'(busy), 1);
            chk("no_early_done", 32'(done_o), 0);
            @(posedge aclk);
            #1;
        end
        arm = 1'b0;
        chk("arm_ignored_wait", 32'(s_ready), 0);
        chk("pe_start_count", 32'(pe_cnt - pe0), 1);
        chk("write_count", 32'(wr_cnt - w0), 32'(WORDS));
        chk("sb_drained", 32'(sb_q.size()), 0);
        pe_done = 1'b1;
        @(negedge aclk);
        chk("done_pulse", 32'(done_o), 1);
        chk("busy_done_cycle", 32'(busy), 1);
        @(posedge aclk);
        #1;
        pe_done = 1'b0;
        chk("busy_idle", 32'(busy), 0);
        chk("done_off", 32'(done_o), 0);
        chk("done_count", 32'(done_cnt - d0), 1);
        chk("err_end", 32'(err), 32'(v.err_end));
    endtask

    task automatic reset_mid();
        bit ok;
        int pe0;
        int w0;
        arm_it();
        for (int i = 0; i < 1000; i++) begin
            send(i, 1'b0, ok);
            if (!ok) return;
        end
        // Word 499 is on the bus now; reset must squash it.
        sb_q.delete(sb_q.size() - 1);
        pe0     = pe_cnt;
        w0      = wr_cnt;
        aresetn = 1'b0;
        #1;
        chk("rst_we_during", 32'(BRAM_WE), 0);
        chk("rst_ready_during", 32'(s_ready), 0);
        chk("rst_busy_during", 32'(busy), 0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        chk("rst_we_after", 32'(BRAM_WE), 0);
        chk("rst_ready_after", 32'(s_ready), 0);
        chk("rst_busy_after", 32'(busy), 0);
        chk("rst_err_after", 32'(err), 0);
        repeat (5) @(posedge aclk);
        #1;
        chk("rst_no_writes", 32'(wr_cnt - w0), 0);
        chk("rst_no_pe_start", 32'(pe_cnt - pe0), 0);
        chk("rst_idle", 32'(busy), 0);
    endtask

    initial begin
        vecs[0] = '{0,  TOTAL - 1, -1,  3,   1'b0, 1'b0};
        vecs[1] = '{50, TOTAL - 1, 500, 7,   1'b0, 1'b0};
        vecs[2] = '{0,  100,       -1,  500, 1'b1, 1'b1};
        vecs[3] = '{25, -1,        -1,  0,   1'b0, 1'b1};
        vecs[4] = '{0,  TOTAL - 1, -1,  1,   1'b0, 1'b0};

        aresetn = 1'b0;
        arm     = 1'b0;
        s_valid = 1'b0;
        s_data  = 16'h0;
        s_last  = 1'b0;
        pe_done = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("reset_s_ready", 32'(s_ready), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_err", 32'(err), 0);
        chk("reset_pe_start", 32'(pe_start), 0);
        chk("reset_done", 32'(done_o), 0);
        chk("reset_we", 32'(BRAM_WE), 0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("post_reset_busy", 32'(busy), 0);
        chk("post_reset_s_ready", 32'(s_ready), 0);

        pe_done = 1'b1;
        @(negedge aclk);
        chk("pe_done_idle_ignored", 32'(done_o), 0);
        @(posedge aclk);
        #1;
        pe_done = 1'b0;
        chk("pe_done_idle_busy", 32'(busy), 0);

        for (int v = 0; v < 4; v++) run_txn(vecs[v]);
        reset_mid();
        run_txn(vecs[4]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
